// File: rtl/stack_unit_if.sv
// ============================================================================
// Module   : stack_unit_if
// Brief    : Request, register-file and data-memory signals of stack_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stack_unit_if #(
    parameter int DATA_W = 8
);
    logic              op_valid;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] flags_in;
    logic [7:0]        sp_in;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] pop_data;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] flags_out;
    logic              sp_en;
    logic              sp_op;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;

    modport master (
        output op_valid, op_code, data_in, pc_in, flags_in, sp_in, mem_rdata,
        input  busy, done, err, pop_data, pc_out, flags_out,
               sp_en, sp_op, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  op_valid, op_code, data_in, pc_in, flags_in, sp_in, mem_rdata,
        output busy, done, err, pop_data, pc_out, flags_out,
               sp_en, sp_op, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

`default_nettype wire

// File: rtl/stack_unit.sv
// ============================================================================
// Module   : stack_unit
// Brief    : Multi-cycle PUSH/POP/CALL/RET/INT/RTI sequencer driving memory
//            and the register file's SP controls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_unit #(
    parameter int         DATA_W      = 8,
    parameter logic [7:0] STACK_BASE  = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'h80
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);

    localparam logic [2:0] c_op_push = 3'd1;
    localparam logic [2:0] c_op_pop  = 3'd2;
    localparam logic [2:0] c_op_call = 3'd3;
    localparam logic [2:0] c_op_ret  = 3'd4;
    localparam logic [2:0] c_op_int  = 3'd5;
    localparam logic [2:0] c_op_rti  = 3'd6;

    localparam logic [7:0] c_int_min = STACK_LIMIT + 8'd1;
    localparam logic [7:0] c_pop_max = STACK_BASE - 8'd1;
    localparam logic [7:0] c_rti_max = STACK_BASE - 8'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR1  = 3'd1;
    localparam logic [2:0] S_WR2  = 3'd2;
    localparam logic [2:0] S_INC  = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_CAP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_flags;
    logic              r_err;
    logic              r_pass;
    logic [DATA_W-1:0] r_pop_data;
    logic [DATA_W-1:0] r_pc_out;
    logic [DATA_W-1:0] r_flags_out;

    logic              w_accept;
    logic              w_bound_ok;
    logic              w_is_write;

    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic              w_sp_en;
    logic              w_sp_op;
    logic [7:0]        w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              w_mem_re;

    // Request decode and bound check against the live SP
    always_comb begin
        w_accept   = 1'b0;
        w_bound_ok = 1'b0;
        w_is_write = 1'b0;
        if (bus.op_valid) begin
            case (bus.op_code)
                c_op_push, c_op_call: begin
                    w_accept   = 1'b1;
                    w_is_write = 1'b1;
                    w_bound_ok = (bus.sp_in >= STACK_LIMIT);
                end
                c_op_int: begin
                    w_accept   = 1'b1;
                    w_is_write = 1'b1;
                    w_bound_ok = (bus.sp_in >= c_int_min);
                end
                c_op_pop, c_op_ret: begin
                    w_accept   = 1'b1;
                    w_bound_ok = (bus.sp_in <= c_pop_max);
                end
                c_op_rti: begin
                    w_accept   = 1'b1;
                    w_bound_ok = (bus.sp_in <= c_rti_max);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_bound_ok)     w_next = S_DONE;
                    else if (w_is_write) w_next = S_WR1;
                    else                 w_next = S_INC;
                end
            end
            S_WR1:   w_next = (r_op == c_op_int) ? S_WR2 : S_DONE;
            S_WR2:   w_next = S_DONE;
            S_INC:   w_next = S_RD;
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = ((r_op == c_op_rti) && !r_pass) ? S_INC : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_sp_en     = 1'b0;
        w_sp_op     = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        case (r_state)
            S_WR1: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = bus.sp_in;
                w_mem_wdata = (r_op == c_op_push) ? r_data : r_pc;
                w_sp_en     = 1'b1;
            end
            S_WR2: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = bus.sp_in;
                w_mem_wdata = r_flags;
                w_sp_en     = 1'b1;
            end
            S_INC: begin
                w_sp_en = 1'b1;
                w_sp_op = 1'b1;
            end
            S_RD: begin
                w_mem_re   = 1'b1;
                w_mem_addr = bus.sp_in;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = r_err;
            end
            default: ;
        endcase
    end

    // Operand latch and result capture; RTI pops flags first, then PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= '0;
            r_data      <= '0;
            r_pc        <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_pass      <= 1'b0;
            r_pop_data  <= '0;
            r_pc_out    <= '0;
            r_flags_out <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_accept) begin
                r_op    <= bus.op_code;
                r_data  <= bus.data_in;
                r_pc    <= bus.pc_in;
                r_flags <= bus.flags_in;
                r_err   <= !w_bound_ok;
                r_pass  <= 1'b0;
            end
            if (r_state == S_CAP) begin
                case (r_op)
                    c_op_pop: r_pop_data <= bus.mem_rdata;
                    c_op_ret: r_pc_out   <= bus.mem_rdata;
                    c_op_rti: begin
                        if (!r_pass) begin
                            r_flags_out <= bus.mem_rdata;
                            r_pass      <= 1'b1;
                        end else begin
                            r_pc_out <= bus.mem_rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
    assign bus.pop_data  = r_pop_data;
    assign bus.pc_out    = r_pc_out;
    assign bus.flags_out = r_flags_out;
    assign bus.sp_en     = w_sp_en;
    assign bus.sp_op     = w_sp_op;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_re    = w_mem_re;

endmodule

`default_nettype wire

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Multi-cycle sequencer that executes stack operations for the core: PUSH, POP, CALL, RET, interrupt entry (INT) and return-from-interrupt (RTI).
- Drives the data-memory port and the register file's SP_EN/SP_OP controls, so SP (R3) is only ever modified through the register file.
- Reads the current SP back from the register file's R3 read path.
- Sits beside the execute/memory stage; the pipeline stalls while busy is high.

Parameters:
- DATA_W, 8, width of data, PC and flags words.
- STACK_BASE, 8'hFF, SP value for an empty stack (register-file reset value of R3).
- STACK_LIMIT, 8'h80, lowest address a push may write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request; sampled only in IDLE.
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as NOP).
- data_in  in  DATA_W  PUSH operand.
- pc_in  in  DATA_W  return PC for CALL and INT.
- flags_in  in  DATA_W  flags word for INT.
- sp_in  in  8  current R3 value from the register file.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high together with done when an op is aborted on a bound violation.
- pop_data  out  DATA_W  result of POP.
- pc_out  out  DATA_W  popped PC for RET and RTI.
- flags_out  out  DATA_W  popped flags for RTI.
- sp_en  out  1  to register file SP_EN.
- sp_op  out  1  to register file SP_OP; 1 = increment, 0 = decrement.
- mem_addr  out  8  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.

Behaviour:
Reset (rst low, asynchronous):
- State goes to IDLE.
- All outputs go to 0; pop_data, pc_out and flags_out clear to 0.
- Reset mid-operation abandons the op with no done pulse. The register file resets SP to STACK_BASE independently.

Convention:
- Push writes M[SP] and then decrements SP.
- Pop increments SP and then reads M[SP].
- mem_we/mem_re/sp_en/mem_addr/mem_wdata are decoded from the state and are 0 outside the cycles listed below.

States: IDLE, WR1, WR2, INC, RD, CAP, DONE.

IDLE:
- On op_valid with a non-NOP code, latch op_code, data_in, pc_in and flags_in, then check bounds against sp_in.
- PUSH/CALL need sp_in >= STACK_LIMIT.
- INT needs sp_in >= STACK_LIMIT+1.
- POP/RET need sp_in <= STACK_BASE-1.
- RTI needs sp_in <= STACK_BASE-2.
- On violation go to DONE with err set; no memory access and no SP change.
- Otherwise go to WR1 for PUSH/CALL/INT, or INC for POP/RET/RTI.
- NOP and reserved codes are ignored; the unit stays in IDLE.

WR1:
- mem_we=1, mem_addr=sp_in, sp_en=1, sp_op=0.
- mem_wdata = data_in (PUSH) or pc_in (CALL/INT).
- Next state: WR2 if INT, else DONE.

WR2 (INT only):
- mem_we=1, mem_addr=sp_in (already decremented), mem_wdata=flags, sp_en=1, sp_op=0.
- Next state: DONE.

INC:
- sp_en=1, sp_op=1.
- Next state: RD.

RD:
- mem_re=1, mem_addr=sp_in (already incremented).
- Next state: CAP.

CAP:
- Register mem_rdata into pop_data (POP), pc_out (RET, or the second pass of RTI) or flags_out (first pass of RTI).
- RTI first pass returns to INC; otherwise go to DONE.

DONE:
- done=1 for one cycle, err as decided in IDLE.
- Next state: IDLE; a new op is accepted in the following cycle.

Other rules:
- Result registers hold their value until overwritten by a later op.
- Latency from the accept edge to the done cycle: PUSH/CALL 2 cycles, INT 3, POP/RET 4, RTI 7; an error costs 1.
- While busy, the pipeline must not write R3 through wenabel. SP_EN wins in the register file on the same edge.
- SP arithmetic is 8-bit; the bound checks guarantee the stack never wraps.

Test Plan:
- Reset, then PUSH data_in=0x5A -> M[0xFF]=0x5A, SP=0xFE, done 2 cycles after accept, err=0.
- PUSH 0x11, PUSH 0x22, POP, POP -> pop_data 0x22 then 0x11, SP returns to 0xFF, each POP done 4 cycles after accept.
- INT pc_in=0x40 flags_in=0x03 at SP=0xFF -> M[0xFF]=0x40, M[0xFE]=0x03, SP=0xFD; RTI -> flags_out=0x03, pc_out=0x40, SP=0xFF.
- POP with SP=0xFF -> done and err 1 cycle after accept, no mem_re, no sp_en, pop_data unchanged; RTI at SP=0xFE -> same error behaviour.
- Fill until SP=0x7F, then PUSH -> err=1, no mem_we, SP stays 0x7F; INT at SP=0x80 -> err=1.
- Assert rst low during RD of a POP -> outputs 0 immediately, state IDLE, no done pulse; a PUSH after reset completes normally.
